// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and sizing helpers for the bit-serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference and borrow cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic dif,
  output logic bout
);
  assign dif  = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first unsigned A-B over WIDTH cycles with held result and borrow-out
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             dif, bout, last, load;
  logic [WIDTH-1:0] sr_nx;
  full_subtractor u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .dif  (dif),
    .bout (bout)
  );
  assign last  = cnt == CW'(WIDTH - 1);
  assign load  = start && state != RUN;
  assign sr_nx = {dif, sr[WIDTH-1:1]};
  always_comb
    state_nx = (state == RUN) ? (last ? FIN : RUN) : (start ? RUN : IDLE);
  // a load from FIN restarts immediately, giving the WIDTH+1 cycle back-to-back rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      br    <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      d     <= '0;
      bo    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        sa  <= a;
        sb  <= b;
        br  <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= bout;
        sr  <= sr_nx;
        cnt <= cnt + CW'(1);
        if (last) begin
          d  <= sr_nx;
          bo <= bout;
        end
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == FIN;
endmodule
